// File: rtl/uart_rx_receiver.sv
// 8-N-1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// parallel byte output with valid/ack handshake, sticky framing/overrun flags.
module uart_rx_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_rx_s;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_W-1:0]       r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_busy;
    logic                   w_start_ok;
    logic                   w_data_sample;
    logic                   w_stop_sample;

    assign w_rx_s = r_sync2;

    // Synchronizer resets to 1 so the line reads idle out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_start_ok    = 1'b0;
        w_data_sample = 1'b0;
        w_stop_sample = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) w_next_state = START;
            end
            START: begin
                // A start bit that is high again at its midpoint is a glitch
                if (r_cnt == CNT_MID) begin
                    if (w_rx_s) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = DATA;
                        w_start_ok   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_data_sample = 1'b1;
                    if (r_bit_idx == BIT_LAST) w_next_state = STOP;
                end
            end
            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_stop_sample = 1'b1;
                    w_next_state  = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Baud counter: held at 0 in IDLE, cleared on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_next_state != r_state) || (r_state == IDLE)) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_start_ok) begin
                r_bit_idx <= '0;
            end else if (w_data_sample) begin
                r_bit_idx <= (r_bit_idx == BIT_LAST) ? '0 : r_bit_idx + BIT_W'(1);
            end
            if (w_data_sample) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        end
    end

    // Byte delivery and handshake; a new event on the stop sample wins over ack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            if (w_stop_sample && w_rx_s) begin
                r_data      <= r_shift;
                r_valid     <= 1'b1;
                r_frame_err <= rx_ack ? 1'b0 : r_frame_err;
                r_overrun   <= rx_ack ? 1'b0 : (r_overrun | r_valid);
            end else if (w_stop_sample) begin
                r_frame_err <= 1'b1;
                r_valid     <= rx_ack ? 1'b0 : r_valid;
                r_overrun   <= rx_ack ? 1'b0 : r_overrun;
            end else if (rx_ack) begin
                r_valid     <= 1'b0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_receiver.sv
// Directed + randomized bench for uart_rx_receiver; expected outputs come from
// a frame-level model of the receiver's delivery/handshake rules.
module tb_uart_rx_receiver;

    localparam int unsigned CPB      = 16;
    localparam int unsigned DBITS    = 8;
    localparam int unsigned ACK_EDGE = 3 + CPB / 2 + 9 * CPB - 1;

    logic             clk;
    logic             reset;
    logic             rx_in;
    logic             rx_ack;
    logic [DBITS-1:0] rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    int n_checks;
    int n_err;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_fe;
    logic       m_ov;

    uart_rx_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DBITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line idle between frames, so busy is expected low at every check point
    task automatic check_all(input string tag);
        check({tag, ".rx_data"},   32'(rx_data),   32'(m_data));
        check({tag, ".rx_valid"},  32'(rx_valid),  32'(m_valid));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        check({tag, ".overrun"},   32'(overrun),   32'(m_ov));
        check({tag, ".busy"},      32'(busy),      32'(0));
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] line;
        line = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_in = line[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_same);
        if (stop_ok) begin
            if (ack_same) begin
                m_ov = 1'b0;
                m_fe = 1'b0;
            end else if (m_valid) begin
                m_ov = 1'b1;
            end
            m_data  = b;
            m_valid = 1'b1;
        end else begin
            if (ack_same) begin
                m_valid = 1'b0;
                m_ov    = 1'b0;
            end
            m_fe = 1'b1;
        end
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    initial begin
        logic [7:0] lb [3];
        logic [7:0] rb;
        logic       bad;
        logic       ack_after;
        int         gap;

        n_checks = 0;
        n_err    = 0;
        model_reset();
        reset  = 1'b1;
        rx_in  = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        idle_bits(1);

        // Single good frame
        send_frame(8'hA5, 1'b1, 10);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_all("t1");
        do_ack();
        check_all("t1_ack");

        // Start-bit glitch then a real frame
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(2);
        check_all("t2_glitch");
        send_frame(8'h3C, 1'b1, 10);
        model_frame(8'h3C, 1'b1, 1'b0);
        check_all("t2_frame");
        do_ack();

        // Framing error: byte discarded, data held
        send_frame(8'h55, 1'b0, 10);
        model_frame(8'h55, 1'b0, 1'b0);
        idle_bits(2);
        check_all("t3_fe");
        do_ack();
        check_all("t3_ack");

        // Overrun with back-to-back frames
        send_frame(8'h11, 1'b1, 10);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 10);
        model_frame(8'h22, 1'b1, 1'b0);
        check_all("t4_ovr");
        do_ack();
        check_all("t4_ack");

        // Ack lands on the cycle of the second frame's stop-bit sample
        send_frame(8'h01, 1'b1, 10);
        model_frame(8'h01, 1'b1, 1'b0);
        check_all("t5_first");
        fork
            send_frame(8'h80, 1'b1, 10);
            begin
                repeat (ACK_EDGE) @(posedge clk);
                @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        model_frame(8'h80, 1'b1, 1'b1);
        check_all("t5_coinc");

        // Reset in the middle of the data bits
        send_frame(8'hFF, 1'b1, 5);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_all("t6_reset");
        reset = 1'b0;
        idle_bits(2);
        send_frame(8'h7E, 1'b1, 10);
        model_frame(8'h7E, 1'b1, 1'b0);
        check_all("t6_frame");
        do_ack();

        // Loopback byte sequence with ack after each
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            send_frame(lb[i], 1'b1, 10);
            model_frame(lb[i], 1'b1, 1'b0);
            check_all($sformatf("loop%0d", i));
            do_ack();
            check_all($sformatf("loop%0d_ack", i));
        end

        // Random bytes, occasional bad stop bits, random ack and gaps
        for (int i = 0; i < 24; i++) begin
            rb        = 8'($urandom);
            bad       = ($urandom_range(0, 6) == 0);
            ack_after = 1'($urandom_range(0, 1));
            gap       = $urandom_range(0, 2);
            if (bad && gap < 2) gap = 2;
            send_frame(rb, ~bad, 10);
            model_frame(rb, ~bad, 1'b0);
            idle_bits(gap);
            check_all($sformatf("rnd%0d", i));
            if (ack_after) begin
                do_ack();
                check_all($sformatf("rnd%0d_ack", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
